pcpi_coproc_mux: RTL and testbench
==================================

// Module: pcpi_coproc_mux
// PURPOSE
//  Sits between the core's single PCPI port and NUM_CP coprocessors (mul, div, ...).
//  Broadcasts each PCPI request and latches the first coprocessor that claims it.
//  Returns only the owner's result to the core.
//  Raises core_illegal when no coprocessor claims within TIMEOUT cycles.
// PARAMETERS
//  NUM_CP   2   number of attached coprocessors (1..8)
//  TIMEOUT  16  cycles in PROBE with no claim before core_illegal; must be >= 4
// PORTS
//  clk           in   1           clock, all logic on posedge
//  resetn        in   1           reset, synchronous, active-low
//  core_valid    in   1           core PCPI request valid, held until ready/illegal or abort
//  core_insn     in   32          instruction word
//  core_rs1      in   32          operand 1
//  core_rs2      in   32          operand 2
//  core_wr       out  1           result writes rd (qualified by core_ready)
//  core_rd       out  32          result data (qualified by core_ready)
//  core_wait     out  1           a coprocessor has claimed and is busy
//  core_ready    out  1           one-cycle completion pulse
//  core_illegal  out  1           one-cycle pulse: no coprocessor claimed
//  cp_valid      out  NUM_CP      per-coprocessor request valid
//  cp_insn       out  32          core_insn broadcast
//  cp_rs1        out  32          core_rs1 broadcast
//  cp_rs2        out  32          core_rs2 broadcast
//  cp_wr         in   NUM_CP      per-coprocessor wr
//  cp_rd         in   32*NUM_CP   packed results, coprocessor i at [32*i +: 32]
//  cp_wait       in   NUM_CP      per-coprocessor wait (claim)
//  cp_ready      in   NUM_CP      per-coprocessor ready pulse
// BEHAVIOUR
//  Reset: state=IDLE, owner=0, count=0; all outputs 0 except the cp_insn/rs1/rs2 passthroughs.
//  FSM states: IDLE, PROBE, OWNED, DRAIN (plus RESP, with the macro only).
//   IDLE: enter PROBE when core_valid=1. Clear count.
//   PROBE: cp_valid = {NUM_CP{core_valid}}. Count increments each cycle.
//    Claim = any cp_wait|cp_ready. Owner = lowest asserted index; go to OWNED.
//    Claim and ready in the same cycle (single-cycle coprocessor) completes immediately.
//    If count reaches TIMEOUT-1 with no claim: core_illegal=1 for 1 cycle, then DRAIN.
//   OWNED: only cp_valid[owner]=core_valid; all other cp_valid bits are 0 from the next cycle.
//    core_wait = cp_wait[owner]. cp_ready of non-owners is ignored.
//    When cp_ready[owner]=1: complete, then go to DRAIN.
//   DRAIN: all cp_valid=0 and core_wait=0. Return to IDLE when core_valid=0.
//    Blocks the stale re-issue caused by a coprocessor's wait-after-ready.
//  Completion: core_ready=1, core_wr=cp_wr[owner], core_rd=cp_rd[owner] for exactly 1 cycle.
//   Outside that cycle core_rd=0.
//  core_wait in PROBE = |cp_wait. core_wait is never high together with core_illegal.
//  Abort: core_valid=0 while in PROBE or OWNED -> IDLE next cycle, all cp_valid=0.
//   Any later cp_ready is discarded; no core_ready, no core_illegal.
//  Mid-operation reset: same as power-on reset; no pending result is delivered.
//  Back-to-back requests: a new request needs at least 1 cycle with core_valid=0 after completion.
// CONFIGURATION
//  PCPI_RESP_REG_EN undefined:
//   core_ready/wr/rd are combinational from the owner in the cp_ready cycle (0 added latency).
//  PCPI_RESP_REG_EN defined:
//   owner result is captured into registers; FSM passes OWNED -> RESP -> DRAIN.
//   core_ready/wr/rd are driven from the registers 1 cycle later (+1 latency).
//   core_wait=1 in RESP; cp_valid[owner]=0 in RESP.
//   core_illegal is unaffected by the macro.
// TESTING
//  T1 DIVU 100/7 on cp1 (div, claims 2 cycles after valid)
//   -> owner=1, core_ready pulse once, core_wr=1, core_rd=14, core_illegal never 1.
//  T2 insn 0x00000013 with no claimer, TIMEOUT=16
//   -> core_illegal pulse exactly 16 cycles after core_valid rises; core_ready=0.
//  T3 cp0 and cp1 assert cp_wait in the same cycle
//   -> owner=0, cp_valid[1]=0 next cycle, cp1 ready ignored, core_rd=cp0 value 0x1234.
//  T4 core_valid dropped 3 cycles into OWNED, then cp1 ready pulses
//   -> no core_ready; state IDLE; next DIV -20/3 returns 0xFFFFFFFA.
//  T5 resetn=0 for 1 cycle mid-OWNED
//   -> all outputs 0 next cycle; owner result later suppressed; new request works.
//  T6 T1 with PCPI_RESP_REG_EN
//   -> same rd=14 with core_ready 1 cycle later; core_wait=1 in that extra cycle.

Source files
------------

// File: rtl/pcpi_coproc_mux_if.sv
// +--------------------------------------------------------------------------+
// | pcpi_coproc_mux_if : core-side PCPI port plus NUM_CP coprocessor ports     |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pcpi_coproc_mux_if #(
  parameter int NUM_CP = 2
);
  logic                     core_valid;
  logic [31:0]              core_insn;
  logic [31:0]              core_rs1;
  logic [31:0]              core_rs2;
  logic                     core_wr;
  logic [31:0]              core_rd;
  logic                     core_wait;
  logic                     core_ready;
  logic                     core_illegal;
  logic [NUM_CP-1:0]        cp_valid;
  logic [31:0]              cp_insn;
  logic [31:0]              cp_rs1;
  logic [31:0]              cp_rs2;
  logic [NUM_CP-1:0]        cp_wr;
  logic [32*NUM_CP-1:0]     cp_rd;
  logic [NUM_CP-1:0]        cp_wait;
  logic [NUM_CP-1:0]        cp_ready;

  // Environment side: drives the core request and the coprocessor responses.
  modport master (
    output core_valid, core_insn, core_rs1, core_rs2,
    input  core_wr, core_rd, core_wait, core_ready, core_illegal,
    input  cp_valid, cp_insn, cp_rs1, cp_rs2,
    output cp_wr, cp_rd, cp_wait, cp_ready
  );

  // Mux side.
  modport slave (
    input  core_valid, core_insn, core_rs1, core_rs2,
    output core_wr, core_rd, core_wait, core_ready, core_illegal,
    output cp_valid, cp_insn, cp_rs1, cp_rs2,
    input  cp_wr, cp_rd, cp_wait, cp_ready
  );
endinterface

`default_nettype wire

// File: rtl/pcpi_coproc_mux.sv
// +--------------------------------------------------------------------------+
// | pcpi_coproc_mux : broadcasts a PCPI request to NUM_CP coprocessors, locks  |
// | onto the first claimer and returns its result; illegal on claim timeout.   |
// | Optional macro PCPI_RESP_REG_EN registers the response (+1 cycle).        |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module pcpi_coproc_mux #(
  parameter int NUM_CP  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              resetn,
  pcpi_coproc_mux_if.slave  bus
);

  localparam int OWN_W = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROBE = 3'd1,
    OWNED = 3'd2,
`ifdef PCPI_RESP_REG_EN
    RESP  = 3'd4,
`endif
    DRAIN = 3'd3
  } state_t;

`ifdef PCPI_RESP_REG_EN
  localparam state_t AFTER_DONE = RESP;
`else
  localparam state_t AFTER_DONE = DRAIN;
`endif

  state_t             state, state_nxt;
  logic [OWN_W-1:0]   owner, owner_nxt;
  logic [CNT_W-1:0]   count, count_nxt;

  logic [NUM_CP-1:0]  claim_vec;
  logic               claim;
  logic [OWN_W-1:0]   claim_idx;
  logic [OWN_W-1:0]   sel;
  logic [31:0]        rd_arr [NUM_CP];
  logic [31:0]        sel_rd;
  logic               sel_wr;
  logic               complete;
  logic [NUM_CP-1:0]  cp_valid_c;
  logic               wait_c;
  logic               illegal_c;

  assign claim_vec = bus.cp_wait | bus.cp_ready;
  assign claim     = |claim_vec;

  always_comb begin
    claim_idx = '0;
    for (int i = NUM_CP - 1; i >= 0; i--) begin
      if (claim_vec[i]) claim_idx = OWN_W'(i);
    end
  end

  for (genvar g = 0; g < NUM_CP; g++) begin : g_rd_unpack
    assign rd_arr[g] = bus.cp_rd[32*g +: 32];
  end

  // While probing, the owner is not yet registered; a single-cycle
  // coprocessor must be selected directly from the claim priority.
  assign sel    = (state == PROBE) ? claim_idx : owner;
  assign sel_rd = rd_arr[sel];
  assign sel_wr = bus.cp_wr[sel];

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    count_nxt  = count;
    complete   = 1'b0;
    cp_valid_c = '0;
    wait_c     = 1'b0;
    illegal_c  = 1'b0;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (bus.core_valid) state_nxt = PROBE;
      end
      PROBE: begin
        cp_valid_c = {NUM_CP{bus.core_valid}};
        wait_c     = |bus.cp_wait;
        count_nxt  = count + CNT_W'(1);
        if (!bus.core_valid) begin
          state_nxt = IDLE;
        end else if (claim) begin
          owner_nxt = claim_idx;
          if (bus.cp_ready[claim_idx]) begin
            complete  = 1'b1;
            state_nxt = AFTER_DONE;
          end else begin
            state_nxt = OWNED;
          end
        end else if (count == CNT_W'(TIMEOUT - 1)) begin
          illegal_c = 1'b1;
          state_nxt = DRAIN;
        end
      end
      OWNED: begin
        cp_valid_c = bus.core_valid ? (NUM_CP'(1) << owner) : '0;
        wait_c     = bus.cp_wait[owner];
        if (!bus.core_valid) begin
          state_nxt = IDLE;
        end else if (bus.cp_ready[owner]) begin
          complete  = 1'b1;
          state_nxt = AFTER_DONE;
        end
      end
`ifdef PCPI_RESP_REG_EN
      RESP: begin
        wait_c    = 1'b1;
        state_nxt = DRAIN;
      end
`endif
      DRAIN: begin
        if (!bus.core_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      count <= count_nxt;
    end
  end

`ifdef PCPI_RESP_REG_EN
  logic        resp_wr;
  logic [31:0] resp_rd;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_wr <= 1'b0;
      resp_rd <= '0;
    end else if (complete) begin
      resp_wr <= sel_wr;
      resp_rd <= sel_rd;
    end
  end

  assign bus.core_ready = (state == RESP);
  assign bus.core_wr    = (state == RESP) & resp_wr;
  assign bus.core_rd    = (state == RESP) ? resp_rd : '0;
`else
  assign bus.core_ready = complete;
  assign bus.core_wr    = complete & sel_wr;
  assign bus.core_rd    = complete ? sel_rd : '0;
`endif

  assign bus.core_wait    = wait_c;
  assign bus.core_illegal = illegal_c;
  assign bus.cp_valid     = cp_valid_c;
  assign bus.cp_insn      = bus.core_insn;
  assign bus.cp_rs1       = bus.core_rs1;
  assign bus.cp_rs2       = bus.core_rs2;

endmodule

`default_nettype wire

// File: tb/tb_pcpi_coproc_mux.sv
// +--------------------------------------------------------------------------+
// | tb_pcpi_coproc_mux : directed self-checking bench for pcpi_coproc_mux.    |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pcpi_coproc_mux;
  localparam int NUM_CP  = 2;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic resetn;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pcpi_coproc_mux_if #(.NUM_CP(NUM_CP)) bus ();

  pcpi_coproc_mux #(.NUM_CP(NUM_CP), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cp_clear();
    bus.cp_wait  = '0;
    bus.cp_ready = '0;
    bus.cp_wr    = '0;
    bus.cp_rd    = '0;
  endtask

  // Caller has applied the completion-cycle coprocessor inputs.
  task automatic complete_check(input string tag, input logic wr, input logic [31:0] rd);
    settle();
`ifdef PCPI_RESP_REG_EN
    chk({tag, "_ready_early"}, bus.core_ready, 0);
    cyc();
    cp_clear();
    settle();
    chk({tag, "_ready"}, bus.core_ready, 1);
    chk({tag, "_wr"}, bus.core_wr, wr);
    chk({tag, "_rd"}, bus.core_rd, rd);
    chk({tag, "_resp_wait"}, bus.core_wait, 1);
    chk({tag, "_resp_cpv"}, bus.cp_valid, 0);
    chk({tag, "_illegal"}, bus.core_illegal, 0);
    cyc();
    bus.core_valid = 1'b0;
    settle();
    chk({tag, "_ready_after"}, bus.core_ready, 0);
    chk({tag, "_rd_after"}, bus.core_rd, 0);
`else
    chk({tag, "_ready"}, bus.core_ready, 1);
    chk({tag, "_wr"}, bus.core_wr, wr);
    chk({tag, "_rd"}, bus.core_rd, rd);
    chk({tag, "_illegal"}, bus.core_illegal, 0);
    cyc();
    bus.core_valid = 1'b0;
    cp_clear();
    settle();
    chk({tag, "_ready_after"}, bus.core_ready, 0);
    chk({tag, "_rd_after"}, bus.core_rd, 0);
    chk({tag, "_drain_cpv"}, bus.cp_valid, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    bus.core_valid = 1'b0;
    bus.core_insn  = 32'hDEAD_BEEF;
    bus.core_rs1   = '0;
    bus.core_rs2   = '0;
    cp_clear();

    // Reset state
    cyc();
    cyc();
    settle();
    chk("rst_ready", bus.core_ready, 0);
    chk("rst_illegal", bus.core_illegal, 0);
    chk("rst_wait", bus.core_wait, 0);
    chk("rst_cpv", bus.cp_valid, 0);
    chk("rst_rd", bus.core_rd, 0);
    chk("rst_insn_pass", bus.cp_insn, 32'hDEAD_BEEF);
    cyc();
    resetn = 1'b1;

    // T1: divide 100/7 on cp1, claim two cycles after valid
    cyc();
    bus.core_valid = 1'b1;
    bus.core_insn  = 32'h0272_5533;
    bus.core_rs1   = 32'd100;
    bus.core_rs2   = 32'd7;
    settle();
    chk("t1_idle_cpv", bus.cp_valid, 0);
    chk("t1_insn_bcast", bus.cp_insn, 32'h0272_5533);
    chk("t1_rs1_bcast", bus.cp_rs1, 32'd100);
    cyc();
    settle();
    chk("t1_probe_cpv", bus.cp_valid, 2'b11);
    chk("t1_probe_wait", bus.core_wait, 0);
    cyc();
    bus.cp_wait = 2'b10;
    settle();
    chk("t1_claim_wait", bus.core_wait, 1);
    chk("t1_claim_illegal", bus.core_illegal, 0);
    cyc();
    settle();
    chk("t1_owned_cpv", bus.cp_valid, 2'b10);
    chk("t1_owned_wait", bus.core_wait, 1);
    cyc();
    settle();
    chk("t1_busy_ready", bus.core_ready, 0);
    cyc();
    bus.cp_wait  = 2'b00;
    bus.cp_ready = 2'b10;
    bus.cp_wr    = 2'b10;
    bus.cp_rd    = {32'd14, 32'h5555_5555};
    complete_check("t1", 1'b1, 32'd14);

    // T2: no claimer, illegal exactly TIMEOUT cycles after valid rises
    cyc();
    bus.core_valid = 1'b1;
    bus.core_insn  = 32'h0000_0013;
    settle();
    chk("t2_start_illegal", bus.core_illegal, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      settle();
      chk($sformatf("t2_illegal_c%0d", k), bus.core_illegal, (k == 16) ? 32'd1 : 32'd0);
    end
    chk("t2_illegal_wait", bus.core_wait, 0);
    chk("t2_illegal_ready", bus.core_ready, 0);
    cyc();
    settle();
    chk("t2_drain_cpv", bus.cp_valid, 0);
    chk("t2_drain_illegal", bus.core_illegal, 0);
    cyc();
    bus.core_valid = 1'b0;
    settle();
    chk("t2_release_cpv", bus.cp_valid, 0);

    // T3: simultaneous claim, lowest index wins
    cyc();
    bus.core_valid = 1'b1;
    bus.core_insn  = 32'h0220_8033;
    settle();
    cyc();
    bus.cp_wait = 2'b11;
    settle();
    chk("t3_probe_cpv", bus.cp_valid, 2'b11);
    cyc();
    bus.cp_ready = 2'b10;
    bus.cp_wr    = 2'b10;
    bus.cp_rd    = {32'h0000_0BAD, 32'h0};
    settle();
    chk("t3_owned_cpv", bus.cp_valid, 2'b01);
    chk("t3_nonowner_ready", bus.core_ready, 0);
    chk("t3_nonowner_rd", bus.core_rd, 0);
    cyc();
    bus.cp_wait  = 2'b10;
    bus.cp_ready = 2'b01;
    bus.cp_wr    = 2'b01;
    bus.cp_rd    = {32'h0000_0BAD, 32'h0000_1234};
    complete_check("t3", 1'b1, 32'h0000_1234);

    // T4: abort three cycles into OWNED, stale ready must be discarded
    cyc();
    bus.core_valid = 1'b1;
    bus.core_insn  = 32'h0220_c033;
    bus.core_rs1   = 32'hFFFF_FFEC;
    bus.core_rs2   = 32'd3;
    settle();
    cyc();
    bus.cp_wait = 2'b10;
    settle();
    cyc();
    settle();
    cyc();
    settle();
    cyc();
    settle();
    chk("t4_owned_cpv", bus.cp_valid, 2'b10);
    cyc();
    bus.core_valid = 1'b0;
    settle();
    chk("t4_abort_cpv", bus.cp_valid, 0);
    chk("t4_abort_ready", bus.core_ready, 0);
    cyc();
    bus.core_valid = 1'b1;
    bus.cp_wait    = 2'b00;
    bus.cp_ready   = 2'b10;
    bus.cp_wr      = 2'b10;
    bus.cp_rd      = {32'h0000_0999, 32'h0};
    settle();
    chk("t4_stale_ready", bus.core_ready, 0);
    chk("t4_stale_rd", bus.core_rd, 0);
    chk("t4_idle_cpv", bus.cp_valid, 0);
    cyc();
    cp_clear();
    bus.cp_wait = 2'b10;
    settle();
    chk("t4_reprobe_cpv", bus.cp_valid, 2'b11);
    cyc();
    bus.cp_wait  = 2'b00;
    bus.cp_ready = 2'b10;
    bus.cp_wr    = 2'b10;
    bus.cp_rd    = {32'hFFFF_FFFA, 32'h0};
    complete_check("t4", 1'b1, 32'hFFFF_FFFA);

    // T5: reset mid-OWNED, then single-cycle coprocessor completes
    cyc();
    bus.core_valid = 1'b1;
    settle();
    cyc();
    bus.cp_wait = 2'b10;
    settle();
    cyc();
    settle();
    chk("t5_owned_cpv", bus.cp_valid, 2'b10);
    cyc();
    resetn = 1'b0;
    settle();
    cyc();
    resetn       = 1'b1;
    bus.cp_ready = 2'b10;
    bus.cp_wr    = 2'b10;
    bus.cp_rd    = {32'h0000_0777, 32'h0};
    settle();
    chk("t5_post_cpv", bus.cp_valid, 0);
    chk("t5_post_wait", bus.core_wait, 0);
    chk("t5_post_ready", bus.core_ready, 0);
    chk("t5_post_rd", bus.core_rd, 0);
    cyc();
    cp_clear();
    bus.cp_ready = 2'b01;
    bus.cp_wr    = 2'b01;
    bus.cp_rd    = {32'h0000_0777, 32'h0000_55AA};
    settle();
    chk("t5_probe_cpv", bus.cp_valid, 2'b11);
    complete_check("t5", 1'b1, 32'h0000_55AA);

    cyc();
    settle();
    chk("end_idle_cpv", bus.cp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
